reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the width of the shared register bank's d/q.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port req, input, N_REQ, per-requester write request, held high until granted.
REQ-006 SHALL have port wdata, input, N_REQ*DATA_W, write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port freeze, input, 1, which inhibits new grants while high.
REQ-008 SHALL have port gnt, output, N_REQ, one-hot grant and acknowledge pulse.
REQ-009 SHALL have port reg_en, output, 1, enable to the shared enable-DFF bank.
REQ-010 SHALL have port reg_d, output, DATA_W, data to the shared enable-DFF bank.
REQ-011 SHALL have port busy, output, 1, high while in state WRITE.
REQ-012 SHALL have port wr_count, output, 16, the number of completed writes, saturating.

Function
REQ-013 SHALL implement an FSM with states IDLE and WRITE.
REQ-014 SHALL make all outputs registered, with no combinational path from any input to any output.
REQ-015 SHALL, in IDLE at an edge where freeze=0 and |req=1: select a winner, load gnt=onehot(winner), load reg_d=wdata[winner], set reg_en=1, and go to WRITE.
REQ-016 SHALL, in IDLE at an edge where |req=0 or freeze=1: hold gnt=0 and reg_en=0, and stay in IDLE.
REQ-017 SHALL, in WRITE, unconditionally return to IDLE at the next edge, clearing gnt and reg_en; reg_d holds its last value.
REQ-018 SHALL, therefore, assert gnt, reg_en and busy for exactly one cycle per grant, giving a throughput of at most one write per 2 cycles.
REQ-019 SHALL give a latency of one edge from req sampled high (in IDLE) to gnt/reg_en high.
REQ-020 SHALL ignore req and freeze while in WRITE.
REQ-021 SHALL arbitrate round-robin using a pointer ptr, width clog2(N_REQ): the winner is the first i with req[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
REQ-022 SHALL, on each grant, update ptr to (winner+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-023 SHALL ensure a requester holding req cannot be starved: it waits at most N_REQ-1 grants to others.
REQ-024 SHALL, at the edge leaving WRITE, increment wr_count by 1; at 16'hFFFF it holds (no wrap).
REQ-025 SHALL have gnt be one-hot or zero at all times.
REQ-026 SHALL, when freeze rises during WRITE, let the current write complete; no further grant follows until freeze=0.
REQ-027 SHALL exclude bits of req at index >= N_REQ from arbitration.

Reset
REQ-028 SHALL, with rst=1 at an edge: set state to IDLE, ptr=0, gnt=0, reg_en=0, reg_d=0, busy=0, wr_count=0.
REQ-029 SHALL let rst take priority over all other inputs.
REQ-030 SHALL, on rst asserted during WRITE, drop reg_en/gnt at that edge; the write is not counted.
REQ-031 SHALL grant nothing at the first edge after rst deasserts unless req is high at that edge; arbitration then starts from requester 0.

Verification
REQ-032 SHALL cover single requester: N_REQ=4, rst released, req=4'b0100, wdata[2]=8'hA5 -> next cycle gnt=4'b0100, reg_en=1, reg_d=8'hA5, busy=1; the cycle after, gnt=0, reg_en=0, wr_count=1.
REQ-033 SHALL cover all requesting: req=4'b1111 held, each requester dropping req after its own gnt -> grant order 0,1,2,3, gnt pulses 2 cycles apart, wr_count=4.
REQ-034 SHALL cover wrap-around: after a grant to 3 (ptr=0), req=4'b1010 -> gnt to 1, then to 3.
REQ-035 SHALL cover freeze: freeze=1 with req=4'b0001 for 5 cycles -> gnt=0 throughout; freeze=0 -> gnt=4'b0001 one edge later.
REQ-036 SHALL cover reset mid-write: rst=1 on the edge while in WRITE -> next cycle gnt=0, reg_en=0, reg_d=0, wr_count=0, ptr=0.
REQ-037 SHALL cover saturation: force wr_count to 16'hFFFE and perform 3 writes -> wr_count=16'hFFFF, stable.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that funnels single-cycle writes from
// N_REQ requesters into one shared enable-DFF register bank.
module reg_write_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  input  logic                      freeze,
  output logic [N_REQ-1:0]          gnt,
  output logic                      reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic                      busy,
  output logic [15:0]               wr_count
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                r_state,    w_state_nxt;
  logic [PTR_W-1:0]      r_ptr,      w_ptr_nxt;
  logic [N_REQ-1:0]      r_gnt,      w_gnt_nxt;
  logic                  r_reg_en,   w_reg_en_nxt;
  logic [DATA_W-1:0]     r_reg_d,    w_reg_d_nxt;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_wr_count, w_wr_count_nxt;

  logic                  w_found;
  logic [PTR_W-1:0]      w_winner;

  // (base + off) modulo N_REQ; works for non-power-of-two N_REQ as well
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  // Round-robin search: first requester at or after the pointer
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_found && req[wrap_add(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_add(r_ptr, k);
      end
    end
  end

  // Next-state and next-output logic; gnt/reg_en default low so pulses last one cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_gnt_nxt      = '0;
    w_reg_en_nxt   = 1'b0;
    w_reg_d_nxt    = r_reg_d;
    w_wr_count_nxt = r_wr_count;
    case (r_state)
      IDLE: begin
        if (!freeze && w_found) begin
          w_state_nxt  = WRITE;
          w_gnt_nxt    = N_REQ'(1) << w_winner;
          w_reg_en_nxt = 1'b1;
          w_reg_d_nxt  = wdata[w_winner*DATA_W +: DATA_W];
          w_ptr_nxt    = wrap_add(w_winner, 32'd1);
        end
      end
      WRITE: begin
        w_state_nxt = IDLE;
        if (r_wr_count != {CNT_W{1'b1}}) w_wr_count_nxt = r_wr_count + CNT_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_reg_en   <= 1'b0;
      r_reg_d    <= '0;
      r_busy     <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_reg_en   <= w_reg_en_nxt;
      r_reg_d    <= w_reg_d_nxt;
      r_busy     <= (w_state_nxt == WRITE);
      r_wr_count <= w_wr_count_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign reg_en   = r_reg_en;
  assign reg_d    = r_reg_d;
  assign busy     = r_busy;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_reg_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   wdata;
  logic              freeze;
  logic [N-1:0]      gnt;
  logic              reg_en;
  logic [DW-1:0]     reg_d;
  logic              busy;
  logic [15:0]       wr_count;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit           m_write;
  int           m_ptr;
  logic [N-1:0] m_gnt;
  logic         m_en;
  logic [DW-1:0] m_d;
  logic [15:0]  m_cnt;

  int wait_cnt [N];
  int order_q[$];
  int cyc_q[$];
  int cyc;

  reg_write_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .freeze   (freeze),
    .gnt      (gnt),
    .reg_en   (reg_en),
    .reg_d    (reg_d),
    .busy     (busy),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    int w;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_write = 0; m_ptr = 0; m_gnt = '0; m_en = 0; m_d = '0; m_cnt = '0;
    end else if (m_write) begin
      m_write = 0; m_gnt = '0; m_en = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (!freeze && (req != '0)) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_gnt   = N'(1) << w;
      m_en    = 1;
      m_d     = wdata[w*DW +: DW];
      m_write = 1;
      m_ptr   = (w + 1) % N;
    end else begin
      m_gnt = '0; m_en = 0;
    end
    #1;
    chk("gnt",      32'(gnt),      32'(m_gnt));
    chk("reg_en",   32'(reg_en),   32'(m_en));
    chk("reg_d",    32'(reg_d),    32'(m_d));
    chk("busy",     32'(busy),     32'(m_write));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    chk("onehot",   32'($onehot0(gnt)), 32'd1);
  endtask

  function automatic int gnt_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; freeze = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] pre_req;
    cyc = 0; rst = 1'b1; req = '0; wdata = '0; freeze = 1'b0;
    m_write = 0; m_ptr = 0; m_gnt = '0; m_en = 0; m_d = '0; m_cnt = '0;

    // reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_cnt", 32'(wr_count), 32'd0);
    step();
    chk("post_rst_idle", 32'(gnt), 32'd0);

    // single requester
    wdata = 32'h00A5_0000; req = 4'b0100;
    step();
    chk("single_gnt",  32'(gnt), 32'h4);
    chk("single_d",    32'(reg_d), 32'hA5);
    chk("single_busy", 32'(busy), 32'd1);
    req = req & ~m_gnt;
    step();
    chk("single_gnt0", 32'(gnt), 32'd0);
    chk("single_cnt",  32'(wr_count), 32'd1);

    // all requesting, order 0..3 two cycles apart
    do_reset();
    wdata = 32'h4433_2211; req = 4'b1111;
    order_q.delete(); cyc_q.delete();
    for (int s = 0; s < 9; s++) begin
      step();
      if (gnt != '0) begin order_q.push_back(gnt_idx(gnt)); cyc_q.push_back(cyc); end
      req = req & ~m_gnt;
    end
    chk("all_ngrants", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < order_q.size(); i++) chk("all_order", 32'(order_q[i]), 32'(i));
    for (int i = 1; i < cyc_q.size(); i++) chk("all_spacing", 32'(cyc_q[i] - cyc_q[i-1]), 32'd2);
    chk("all_cnt", 32'(wr_count), 32'd4);

    // wrap-around: ptr is 0 after the grant to 3
    req = 4'b1010;
    order_q.delete();
    for (int s = 0; s < 5; s++) begin
      step();
      if (gnt != '0) order_q.push_back(gnt_idx(gnt));
      req = req & ~m_gnt;
    end
    chk("wrap_n",  32'(order_q.size()), 32'd2);
    if (order_q.size() == 2) begin
      chk("wrap_first",  32'(order_q[0]), 32'd1);
      chk("wrap_second", 32'(order_q[1]), 32'd3);
    end

    // freeze holds off grants
    freeze = 1'b1; req = 4'b0001;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("freeze_gnt0", 32'(gnt), 32'd0);
    end
    freeze = 1'b0;
    step();
    chk("unfreeze_gnt", 32'(gnt), 32'd1);
    // freeze rising during WRITE: current write still completes
    freeze = 1'b1; req = 4'b0010;
    step();
    chk("freeze_wr_done", 32'(reg_en), 32'd0);
    step();
    chk("freeze_hold", 32'(gnt), 32'd0);
    freeze = 1'b0; req = '0;
    step();

    // reset mid-write
    wdata = 32'h0000_5A00; req = 4'b0010;
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1; req = '0;
    step();
    chk("mid_gnt", 32'(gnt), 32'd0);
    chk("mid_en",  32'(reg_en), 32'd0);
    chk("mid_d",   32'(reg_d), 32'd0);
    chk("mid_cnt", 32'(wr_count), 32'd0);
    rst = 1'b0; req = 4'b1111;
    step();
    chk("mid_ptr0", 32'(gnt), 32'd1);
    req = req & ~m_gnt;
    while (req != '0 || m_write) begin step(); req = req & ~m_gnt; end
    step();

    // saturation
    @(negedge clk);
    force dut.r_wr_count = 16'hFFFE;
    #1;
    release dut.r_wr_count;
    m_cnt = 16'hFFFE;
    for (int s = 0; s < 3; s++) begin
      req = 4'b0100; wdata = 32'($urandom);
      step(); req = req & ~m_gnt;
      step();
    end
    chk("sat_cnt", 32'(wr_count), 32'hFFFF);
    step(); step();
    chk("sat_stable", 32'(wr_count), 32'hFFFF);

    // randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int s = 0; s < 3000; s++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 0) wdata[i*DW +: DW] = DW'($urandom);
      freeze = ($urandom_range(0, 9) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      pre_req = req;
      step();
      if (rst) begin
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end else if (m_gnt != '0) begin
        for (int i = 0; i < N; i++) begin
          if (m_gnt[i]) begin
            chk("starve", 32'(wait_cnt[i] <= N - 1), 32'd1);
            wait_cnt[i] = 0;
          end else if (pre_req[i]) begin
            wait_cnt[i]++;
          end
        end
      end
      req = req & ~m_gnt;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
